// File: rtl/gmux_seq_ctrl.sv
// Sequencer for one GMUX global-clock cell: gates dynamic enables, switches source, then staggers
// quadrant re-enable. Optional ABORT/ABORTED ports are built when GMUX_SEQ_ABORT_EN is defined.
module gmux_seq_ctrl #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int STAGGER_CYCLES = 2,
   parameter int CNT_W          = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic       REQ_SSEL,
   input  logic [3:0] REQ_QEN,
   input  logic [3:0] REQ_VLP,
   output logic       SSEL,
   output logic       TL_DEN,
   output logic       TL_DYNEN,
   output logic       TL_SEN,
   output logic       TL_VLP,
   output logic       TR_DEN,
   output logic       TR_DYNEN,
   output logic       TR_SEN,
   output logic       TR_VLP,
   output logic       BL_DEN,
   output logic       BL_DYNEN,
   output logic       BL_SEN,
   output logic       BL_VLP,
   output logic       BR_DEN,
   output logic       BR_DYNEN,
   output logic       BR_SEN,
   output logic       BR_VLP,
   output logic       BUSY,
   output logic       DONE,
`ifdef GMUX_SEQ_ABORT_EN
   input  logic       ABORT,
   output logic       ABORTED,
`endif
   output logic [2:0] dbg_state
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_GATE   = 3'd1;
   localparam logic [2:0] ST_SWITCH = 3'd2;
   localparam logic [2:0] ST_ENABLE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       slot;
   logic             l_ssel;
   logic [3:0]       l_qen;
   logic             ssel_r;
   logic [3:0]       den, sen, dynen, vlp;
   logic             busy_r, done_r;
`ifdef GMUX_SEQ_ABORT_EN
   logic             aborted_r;
`endif

   logic [2:0] search_start;
   logic       nxt_found;
   logic [1:0] nxt_idx;
   logic       go_enable;

   // Next enabled quadrant at or after the search start; lowest index wins.
   always_comb begin
      search_start = 3'd0;
      if (state == ST_ENABLE) search_start = {1'b0, slot} + 3'd1;
      nxt_found = 1'b0;
      nxt_idx   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (l_qen[i] && (3'(i) >= search_start)) begin
            nxt_found = 1'b1;
            nxt_idx   = 2'(i);
         end
      end
      go_enable = (cnt == '0) &&
                  (((state == ST_GATE) && (l_ssel == ssel_r)) ||
                   (state == ST_SWITCH) || (state == ST_ENABLE));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         slot   <= 2'd0;
         l_ssel <= 1'b0;
         l_qen  <= 4'd0;
         ssel_r <= 1'b0;
         den    <= 4'd0;
         sen    <= 4'd0;
         dynen  <= 4'd0;
         vlp    <= 4'd0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
`ifdef GMUX_SEQ_ABORT_EN
         aborted_r <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
`ifdef GMUX_SEQ_ABORT_EN
         aborted_r <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (REQ_VALID) begin
                  l_ssel <= REQ_SSEL;
                  l_qen  <= REQ_QEN;
                  state  <= ST_GATE;
                  busy_r <= 1'b1;
                  cnt    <= SETTLE_LOAD;
                  dynen  <= 4'd0;
                  den    <= den & REQ_QEN;
                  sen    <= sen & REQ_QEN;
                  vlp    <= (vlp & REQ_QEN) | (REQ_VLP & ~REQ_QEN);
               end
            end
            ST_GATE: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else if (l_ssel != ssel_r) begin
                  // All DYNEN are already low here, so the source can change safely.
                  state  <= ST_SWITCH;
                  ssel_r <= l_ssel;
                  cnt    <= SETTLE_LOAD;
               end
            end
            ST_SWITCH, ST_ENABLE: begin
               if (cnt != '0) cnt <= cnt - CNT_ONE;
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               busy_r <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase

         if (go_enable) begin
            if (nxt_found) begin
               state        <= ST_ENABLE;
               slot         <= nxt_idx;
               cnt          <= STAGGER_LOAD;
               den[nxt_idx]   <= 1'b1;
               sen[nxt_idx]   <= 1'b1;
               dynen[nxt_idx] <= 1'b1;
               vlp[nxt_idx]   <= 1'b0;
            end else begin
               state  <= ST_DONE;
               done_r <= 1'b1;
               cnt    <= '0;
            end
         end

`ifdef GMUX_SEQ_ABORT_EN
         // Abort parks every quadrant in low-power and keeps the current source.
         if (ABORT && ((state == ST_GATE) || (state == ST_SWITCH) || (state == ST_ENABLE))) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            den       <= 4'd0;
            sen       <= 4'd0;
            dynen     <= 4'd0;
            vlp       <= 4'hF;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b1;
         end
`endif
      end
   end

   assign REQ_READY = (state == ST_IDLE) & ~RST;
   assign SSEL      = ssel_r;
   assign BUSY      = busy_r;
   assign DONE      = done_r;
   assign dbg_state = state;
`ifdef GMUX_SEQ_ABORT_EN
   assign ABORTED   = aborted_r;
`endif

   assign TL_DEN = den[0];  assign TL_DYNEN = dynen[0];  assign TL_SEN = sen[0];  assign TL_VLP = vlp[0];
   assign TR_DEN = den[1];  assign TR_DYNEN = dynen[1];  assign TR_SEN = sen[1];  assign TR_VLP = vlp[1];
   assign BL_DEN = den[2];  assign BL_DYNEN = dynen[2];  assign BL_SEN = sen[2];  assign BL_VLP = vlp[2];
   assign BR_DEN = den[3];  assign BR_DYNEN = dynen[3];  assign BR_SEN = sen[3];  assign BR_VLP = vlp[3];

endmodule

// File: tb/tb_gmux_seq_ctrl.sv
// Self-checking bench for gmux_seq_ctrl: per-cycle output model plus a DONE-result scoreboard.
module tb_gmux_seq_ctrl;

   localparam int S = 4;
   localparam int T = 2;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_ssel;
   logic [3:0] req_qen;
   logic [3:0] req_vlp;
   logic       ssel;
   logic       tl_den, tl_dynen, tl_sen, tl_vlp;
   logic       tr_den, tr_dynen, tr_sen, tr_vlp;
   logic       bl_den, bl_dynen, bl_sen, bl_vlp;
   logic       br_den, br_dynen, br_sen, br_vlp;
   logic       busy;
   logic       done;
   logic       abort;
   logic       aborted;
   logic [2:0] dbg_state;

   gmux_seq_ctrl #(.SETTLE_CYCLES(S), .STAGGER_CYCLES(T), .CNT_W(8)) dut (
      .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
      .REQ_SSEL(req_ssel), .REQ_QEN(req_qen), .REQ_VLP(req_vlp), .SSEL(ssel),
      .TL_DEN(tl_den), .TL_DYNEN(tl_dynen), .TL_SEN(tl_sen), .TL_VLP(tl_vlp),
      .TR_DEN(tr_den), .TR_DYNEN(tr_dynen), .TR_SEN(tr_sen), .TR_VLP(tr_vlp),
      .BL_DEN(bl_den), .BL_DYNEN(bl_dynen), .BL_SEN(bl_sen), .BL_VLP(bl_vlp),
      .BR_DEN(br_den), .BR_DYNEN(br_dynen), .BR_SEN(br_sen), .BR_VLP(br_vlp),
      .BUSY(busy), .DONE(done),
`ifdef GMUX_SEQ_ABORT_EN
      .ABORT(abort), .ABORTED(aborted),
`endif
      .dbg_state(dbg_state)
   );

`ifndef GMUX_SEQ_ABORT_EN
   assign aborted = 1'b0;
`endif

   logic [3:0] o_den, o_sen, o_dyn, o_vlp;
   assign o_den = {br_den, bl_den, tr_den, tl_den};
   assign o_sen = {br_sen, bl_sen, tr_sen, tl_sen};
   assign o_dyn = {br_dynen, bl_dynen, tr_dynen, tl_dynen};
   assign o_vlp = {br_vlp, bl_vlp, tr_vlp, tl_vlp};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // scoreboard: {latency[7:0], ssel, den, sen, dynen, vlp} expected at DONE
   logic [24:0] exp_q[$];

   // reference model of quadrant outputs left by the previous sequence
   logic       m_ssel;
   logic [3:0] m_den, m_sen, m_vlp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_ssel = 1'b0;
      m_den  = 4'd0;
      m_sen  = 4'd0;
      m_vlp  = 4'd0;
   endtask

   task automatic wait_ready(input string tag);
      for (int k = 0; k < 50 && !req_ready; k++) step();
      check(tag, 32'(req_ready), 32'd1);
   endtask

   task automatic issue(input logic s, input logic [3:0] q, input logic [3:0] v);
      req_valid = 1'b1;
      req_ssel  = s;
      req_qen   = q;
      req_vlp   = v;
      step();
      req_valid = 1'b0;
   endtask

   // Drives one request and checks every cycle up to DONE, then READY afterwards.
   task automatic run_req(input logic s, input logic [3:0] q, input logic [3:0] v);
      int         on_cyc[4];
      int         base, rank, lat;
      logic       sw, done_seen;
      logic [3:0] eden, esen, edyn, evlp;
      logic       essel;
      logic [24:0] exp_res;
      sw   = (s != m_ssel);
      base = S + (sw ? S : 0) + 1;
      rank = 0;
      for (int i = 0; i < 4; i++) begin
         on_cyc[i] = 0;
         if (q[i]) begin
            on_cyc[i] = base + T * rank;
            rank++;
         end
      end
      lat = base + T * rank;
      for (int i = 0; i < 4; i++) begin
         eden[i] = q[i];
         esen[i] = q[i];
         edyn[i] = q[i];
         evlp[i] = q[i] ? 1'b0 : v[i];
      end
      exp_q.push_back({8'(lat), s, eden, esen, edyn, evlp});

      wait_ready("ready_before_req");
      issue(s, q, v);
      done_seen = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c <= lat) begin
            for (int i = 0; i < 4; i++) begin
               if (q[i]) begin
                  eden[i] = (c >= on_cyc[i]) ? 1'b1 : m_den[i];
                  esen[i] = (c >= on_cyc[i]) ? 1'b1 : m_sen[i];
                  edyn[i] = (c >= on_cyc[i]);
                  evlp[i] = (c >= on_cyc[i]) ? 1'b0 : m_vlp[i];
               end else begin
                  eden[i] = 1'b0;
                  esen[i] = 1'b0;
                  edyn[i] = 1'b0;
                  evlp[i] = v[i];
               end
            end
            essel = (sw && c > S) ? s : m_ssel;
            check($sformatf("cycle%0d_outputs", c),
                  32'({ssel, o_den, o_sen, o_dyn, o_vlp, busy, done, req_ready}),
                  32'({essel, eden, esen, edyn, evlp, 1'b1, (c == lat), 1'b0}));
         end
         if (done) begin
            done_seen = 1'b1;
            if (exp_q.size() > 0) begin
               exp_res = exp_q.pop_front();
               check("done_result", 32'({8'(c), ssel, o_den, o_sen, o_dyn, o_vlp}), 32'(exp_res));
            end
            break;
         end
         step();
      end
      check("done_seen", 32'(done_seen), 32'd1);
      step();
      check("after_done_ready_busy_done", 32'({req_ready, busy, done}), 32'b100);
      m_ssel = s;
      for (int i = 0; i < 4; i++) begin
         m_den[i] = q[i];
         m_sen[i] = q[i];
         m_vlp[i] = q[i] ? 1'b0 : v[i];
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_ssel  = 1'b0;
      req_qen   = 4'd0;
      req_vlp   = 4'd0;
      abort     = 1'b0;
      model_reset();

      // reset held for two cycles
      step();
      check("reset_outputs", 32'({ssel, o_den, o_sen, o_dyn, o_vlp, busy, done}), 32'd0);
      check("reset_ready_low", 32'(req_ready), 32'd0);
      step();
      check("reset_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      step();
      check("ready_after_reset", 32'(req_ready), 32'd1);

      // switch to GHSCK, all quadrants
      run_req(1'b1, 4'b1111, 4'b0000);
      // same source, TL/BL only
      run_req(1'b1, 4'b0101, 4'b1010);
      // switch back, no quadrants
      run_req(1'b0, 4'b0000, 4'b0110);
      // a few random requests
      for (int r = 0; r < 4; r++)
         run_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      // reset in the middle of ENABLE
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      step();
      wait_ready("ready_before_midrst");
      issue(1'b1, 4'b1111, 4'b0000);
      for (int c = 1; c < 10; c++) step();
      check("midrst_pre_dynen", 32'(o_dyn), 32'b0001);
      rst = 1'b1;
      step();
      check("midrst_outputs", 32'({ssel, o_den, o_sen, o_dyn, o_vlp, busy, done}), 32'd0);
      check("midrst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         check("midrst_no_done", 32'({done, busy}), 32'd0);
      end
      run_req(1'b1, 4'b1001, 4'b0110);

`ifdef GMUX_SEQ_ABORT_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      step();
      wait_ready("ready_before_abort");
      issue(1'b1, 4'b1111, 4'b0000);
      for (int c = 1; c < 6; c++) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_outputs", 32'({dbg_state, ssel, o_den, o_dyn, o_sen, o_vlp, aborted, done}),
            32'({3'd0, 1'b1, 4'd0, 4'd0, 4'd0, 4'hF, 1'b1, 1'b0}));
      step();
      check("abort_pulse_end", 32'({aborted, done, req_ready}), 32'b001);
      m_ssel = 1'b1;
      m_vlp  = 4'hF;
      run_req(1'b1, 4'b0110, 4'b1001);
`else
      check("aborted_tied_low", 32'(aborted), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
